// File: rtl/definitions_pkg.sv
// Shared types and defaults for the run controller and its cycle counter.
package definitions;

    typedef enum logic [1:0] {RC_IDLE, RC_RST, RC_RUN, RC_FIN} run_st_t;

    localparam int kMAX_CYCLES = 1000;

endpackage

// File: rtl/cyc_cnt.sv
// Run-cycle counter: cleared on request, counts while enabled, saturates at the run limit.
module cyc_cnt
    import definitions::*;
#(
    parameter int CW         = 16,
    parameter int MAX_CYCLES = kMAX_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          hit
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(MAX_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // The FSM leaves RUN at LIMIT anyway; the guard keeps the count from wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (count_q == LAST);

endmodule

// File: rtl/run_ctl.sv
// Run controller for the single-cycle core: parks the core, arbitrates the dmem port
// between host and core, and times each run against a cycle limit.
module run_ctl
    import definitions::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = kMAX_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          fin,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          core_rst,
    input  logic          core_done,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_di,
    input  logic [DW-1:0] dm_dout
);

    run_st_t state_q, state_d;
    logic    fin_q, fin_d;
    logic    timeout_q, timeout_d;
    logic    cnt_clr, cnt_en, cnt_hit;

    assign cnt_clr = (state_q == RC_RST);
    assign cnt_en  = (state_q == RC_RUN);

    cyc_cnt #(
        .CW         (CW),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cycles),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RC_IDLE;
            fin_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fin_q     <= fin_d;
            timeout_q <= timeout_d;
        end
    end

    // Done is checked before the limit so a coincident finish is not a timeout.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        case (state_q)
            RC_IDLE: if (start) state_d = RC_RST;
            RC_RST: begin
                state_d   = RC_RUN;
                timeout_d = 1'b0;
            end
            RC_RUN: begin
                if (core_done) begin
                    state_d   = RC_FIN;
                    timeout_d = 1'b0;
                end else if (cnt_hit) begin
                    state_d   = RC_FIN;
                    timeout_d = 1'b1;
                end
            end
            RC_FIN:  state_d = RC_IDLE;
            default: state_d = RC_IDLE;
        endcase
        fin_d = (state_d == RC_FIN);
    end

    always_comb begin
        busy     = (state_q == RC_RST) || (state_q == RC_RUN);
        core_rst = (state_q != RC_RUN);
        host_gnt = host_req && ((state_q == RC_IDLE) || (state_q == RC_FIN));
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_di    = '0;
        if (host_gnt) begin
            dm_we   = host_we;
            dm_addr = host_addr;
            dm_di   = host_wdata;
        end else if (busy) begin
            dm_we   = core_we && (state_q == RC_RUN);
            dm_addr = core_addr;
            dm_di   = core_wdata;
        end
    end

    assign fin        = fin_q;
    assign timeout    = timeout_q;
    assign host_rdata = dm_dout;
    assign core_rdata = dm_dout;

endmodule
